// File: rtl/node_pkg.sv
// node_pkg: shared encodings for the TIS-100 node sequencer and its datapath bundle.
package node_pkg;
   localparam int WORD_W = 18;
   localparam int NPORT = 4;
   localparam int OP_LSB = 0;
   localparam int SRC_LSB = 4;
   localparam int DST_LSB = 7;
   localparam int IMM_LSB = 10;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_MOV = 4'd1;
   localparam logic [3:0] OP_SWP = 4'd2;
   localparam logic [3:0] OP_SAV = 4'd3;
   localparam logic [3:0] OP_ADD = 4'd4;
   localparam logic [3:0] OP_SUB = 4'd5;
   localparam logic [3:0] OP_NEG = 4'd6;
   localparam logic [3:0] OP_JMP = 4'd7;
   localparam logic [3:0] OP_JEZ = 4'd8;
   localparam logic [3:0] OP_JNZ = 4'd9;
   localparam logic [3:0] OP_JGZ = 4'd10;
   localparam logic [3:0] OP_JLZ = 4'd11;
   localparam logic [3:0] OP_JRO = 4'd12;

   localparam logic [2:0] SRC_ACC = 3'b100;
   localparam logic [2:0] SRC_ZERO = 3'b111;
   localparam logic [2:0] DST_ACC = 3'b100;
   localparam logic [2:0] DST_BAK = 3'b101;
   localparam logic [2:0] DST_NIL = 3'b110;

   localparam logic [1:0] SWPA_MOV = 2'b00;
   localparam logic [1:0] SWPA_ALU = 2'b01;
   localparam logic [1:0] SWPA_ZERO = 2'b10;
   localparam logic [1:0] SWPA_BAK = 2'b11;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_NEG = 2'b10;

   typedef enum logic [1:0] {ST_LOAD = 2'b00, ST_RUN = 2'b01, ST_WAIT = 2'b10} state_e;

   typedef struct packed {
      logic       swp;
      logic [1:0] swpa;
      logic       swpb;
      logic       jmp;
      logic [1:0] alu;
      logic [2:0] src;
      logic [2:0] dst;
      logic [7:0] imm;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '{swp: 1'b0, swpa: SWPA_ZERO, swpb: 1'b0, jmp: 1'b1,
                                   alu: 2'b00, src: 3'b000, dst: DST_NIL, imm: 8'd0};
endpackage

// File: rtl/node_control_if.sv
// node_control_if: input/output port handshakes between a node and its neighbours.
interface node_control_if;
   import node_pkg::*;
   logic [NPORT-1:0] in_valid;
   logic [NPORT-1:0] in_ack;
   logic [NPORT-1:0] out_valid;
   logic [NPORT-1:0] out_ack;
   modport master (output in_valid, out_ack, input in_ack, out_valid);
   modport slave (input in_valid, out_ack, output in_ack, out_valid);
endinterface

// File: rtl/node_prog_mem.sv
// node_prog_mem: program store with async read; tracks highest written address + 1.
module node_prog_mem
   import node_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [AW-1:0]     addr_i,
   input  logic [WORD_W-1:0] data_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [WORD_W-1:0] rdata_o,
   output logic [AW:0]       len_o
);
   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [AW:0] len_q, len_d, nxt;
   logic ok;

   assign nxt = {1'b0, addr_i} + (AW+1)'(1);
   assign ok = {1'b0, addr_i} < (AW+1)'(DEPTH);
   assign len_d = (we_i && ok && nxt > len_q) ? nxt : len_q;
   assign rdata_o = mem_q[raddr_i];
   assign len_o = len_q;

   always_ff @(posedge clk) begin
      if (we_i && ok) mem_q[addr_i] <= data_i;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) len_q <= '0;
      else len_q <= len_d;
   end
endmodule

// File: rtl/node_control.sv
// node_control: TIS-100 node sequencer; decodes one instruction per cycle into the
// datapath bundle, resolves jumps against ACC and stalls on port handshakes.
module node_control
   import node_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic              prog_we,
   input  logic [AW-1:0]     prog_addr,
   input  logic [WORD_W-1:0] prog_data,
   node_control_if.slave     ports,
   input  logic [7:0]        ACCond,
   output logic              SwpActiveReg,
   output logic [1:0]        SwpinA,
   output logic              SwpinB,
   output logic              jmpInstr,
   output logic [1:0]        ALUdesk,
   output logic [13:0]       datainstr,
   output logic [AW-1:0]     pc,
   output logic [1:0]        state
);
   state_e state_q, state_d;
   logic [AW-1:0] pc_q, pc_d, adv, jt_pc, jro_pc, pc_nxt;
   logic [NPORT-1:0] out_valid_q, out_valid_d, out_set;
   logic [WORD_W-1:0] word;
   logic [AW:0] len, inc, lenm1;
   logic [3:0] op;
   logic [2:0] fsrc, fdst;
   logic [7:0] fimm;
   logic signed [AW+8:0] jro_s;
   logic exec, rd, wr, stall, commit, z, taken;
   ctrl_t dec, ctrl;

   node_prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk(clk), .rst_n(rst_n), .we_i(prog_we && state_q == ST_LOAD), .addr_i(prog_addr),
      .data_i(prog_data), .raddr_i(pc_q), .rdata_o(word), .len_o(len)
   );

   assign op = word[OP_LSB +: 4];
   assign fsrc = word[SRC_LSB +: 3];
   assign fdst = word[DST_LSB +: 3];
   assign fimm = word[IMM_LSB +: 8];

   always_comb begin
      dec = '0;
      dec.imm = fimm;
      case (op)
         OP_MOV: begin dec.src = fsrc; dec.dst = fdst; dec.swpa = SWPA_MOV; end
         OP_SWP: begin dec.swp = 1'b1; dec.swpa = SWPA_BAK; dec.swpb = 1'b1; end
         OP_SAV: begin dec.src = SRC_ACC; dec.dst = DST_BAK; end
         OP_ADD: begin dec.src = fsrc; dec.dst = DST_ACC; dec.swpa = SWPA_ALU; dec.alu = ALU_ADD; end
         OP_SUB: begin dec.src = fsrc; dec.dst = DST_ACC; dec.swpa = SWPA_ALU; dec.alu = ALU_SUB; end
         OP_NEG: begin dec.src = SRC_ZERO; dec.dst = DST_ACC; dec.swpa = SWPA_ALU; dec.alu = ALU_NEG; end
         OP_JMP, OP_JEZ, OP_JNZ, OP_JGZ, OP_JLZ, OP_JRO: dec.jmp = 1'b1;
         default: dec.dst = DST_NIL;
      endcase
   end

   // Only MOV/ADD/SUB honour an encoded source, and only MOV can target an output port.
   assign rd = (op == OP_MOV || op == OP_ADD || op == OP_SUB) && !fsrc[2];
   assign wr = op == OP_MOV && !fdst[2];
   assign stall = (rd && !ports.in_valid[fsrc[1:0]]) ||
                  (wr && out_valid_q[fdst[1:0]] && !ports.out_ack[fdst[1:0]]);
   assign exec = state_q != ST_LOAD && run && len != '0;
   assign commit = exec && !stall;

   always_comb begin
      ctrl = !exec ? CTRL_IDLE : dec;
      ctrl.jmp = ctrl.jmp || (exec && stall);
      ctrl.swp = ctrl.swp && !(exec && stall);
   end

   assign z = ACCond == 8'd0;
   assign taken = op == OP_JMP || (op == OP_JEZ && z) || (op == OP_JNZ && !z) ||
                  (op == OP_JGZ && !ACCond[7] && !z) || (op == OP_JLZ && ACCond[7]);
   assign inc = {1'b0, pc_q} + (AW+1)'(1);
   assign lenm1 = len - (AW+1)'(1);
   assign adv = inc == len ? '0 : inc[AW-1:0];
   assign jt_pc = {1'b0, fimm[AW-1:0]} >= len ? '0 : fimm[AW-1:0];
   assign jro_s = $signed({9'b0, pc_q}) + $signed({{(AW+1){fimm[7]}}, fimm});
   assign jro_pc = jro_s[AW+8] ? '0 : (jro_s >= $signed({8'b0, len})) ? lenm1[AW-1:0] : jro_s[AW-1:0];
   assign pc_nxt = op == OP_JRO ? jro_pc : taken ? jt_pc : adv;

   assign out_set = (commit && wr) ? NPORT'(1) << fdst[1:0] : '0;
   assign out_valid_d = (out_valid_q & ~ports.out_ack) | out_set;
   assign state_d = state_q == ST_LOAD ? (run ? ST_RUN : ST_LOAD) :
                    !run ? ST_LOAD : (exec && stall) ? ST_WAIT : ST_RUN;
   assign pc_d = commit ? pc_nxt : exec ? pc_q : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_LOAD;
         pc_q <= '0;
         out_valid_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q <= pc_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign ports.in_ack = (commit && rd) ? NPORT'(1) << fsrc[1:0] : '0;
   assign ports.out_valid = out_valid_q;
   assign SwpActiveReg = ctrl.swp;
   assign SwpinA = ctrl.swpa;
   assign SwpinB = ctrl.swpb;
   assign jmpInstr = ctrl.jmp;
   assign ALUdesk = ctrl.alu;
   assign datainstr = {ctrl.imm, ctrl.dst, ctrl.src};
   assign pc = pc_q;
   assign state = state_q;
endmodule

// File: tb/tb_node_control.sv
// tb_node_control: directed scenarios for the node sequencer with hand-computed expectations.
module tb_node_control;
   logic clk = 1'b0;
   logic rst_n, run, prog_we;
   logic [3:0] prog_addr;
   logic [17:0] prog_data;
   logic [7:0] ACCond;
   logic SwpActiveReg, SwpinB, jmpInstr;
   logic [1:0] SwpinA, ALUdesk, state;
   logic [13:0] datainstr;
   logic [3:0] pc;
   int checks = 0;
   int errors = 0;

   node_control_if pif();

   node_control #(.DEPTH(16), .AW(4)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .ports(pif), .ACCond(ACCond), .SwpActiveReg(SwpActiveReg),
      .SwpinA(SwpinA), .SwpinB(SwpinB), .jmpInstr(jmpInstr), .ALUdesk(ALUdesk),
      .datainstr(datainstr), .pc(pc), .state(state)
   );

   always #5 clk = ~clk;

   function automatic logic [17:0] w(input logic [3:0] op, input logic [2:0] s, input logic [2:0] d, input logic [7:0] imm);
      return {imm, d, s, op};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      run = 1'b0;
      prog_we = 1'b0;
      pif.in_valid = 4'b0;
      pif.out_ack = 4'b0;
      ACCond = 8'd0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic load(input logic [3:0] a, input logic [17:0] d);
      prog_we = 1'b1;
      prog_addr = a;
      prog_data = d;
      tick();
      prog_we = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (state !== 2'b00) begin errors++; $display("FAIL rst_state got %0d want 0", state); end
      checks++; if (pc !== 4'd0) begin errors++; $display("FAIL rst_pc got %0d want 0", pc); end
      checks++; if (pif.out_valid !== 4'b0) begin errors++; $display("FAIL rst_outv got %b want 0000", pif.out_valid); end
      checks++; if (jmpInstr !== 1'b1 || SwpinA !== 2'b10 || SwpActiveReg !== 1'b0) begin errors++; $display("FAIL rst_idle got jmp=%b swpa=%b swp=%b want 1 10 0", jmpInstr, SwpinA, SwpActiveReg); end
      checks++; if (datainstr[5:3] !== 3'b110) begin errors++; $display("FAIL rst_dst got %b want 110", datainstr[5:3]); end
   endtask

   task automatic test_mov_add();
      do_reset();
      load(4'd0, w(4'd1, 3'b101, 3'b100, 8'd5));
      load(4'd1, w(4'd4, 3'b101, 3'b000, 8'd3));
      run = 1'b1;
      tick();
      checks++; if (state !== 2'b01 || pc !== 4'd0) begin errors++; $display("FAIL mov_start got st=%0d pc=%0d want 1 0", state, pc); end
      checks++; if (datainstr !== {8'd5, 3'b100, 3'b101}) begin errors++; $display("FAIL mov_data got %h want %h", datainstr, {8'd5, 3'b100, 3'b101}); end
      checks++; if (SwpinA !== 2'b00 || jmpInstr !== 1'b0) begin errors++; $display("FAIL mov_ctl got swpa=%b jmp=%b want 00 0", SwpinA, jmpInstr); end
      tick();
      checks++; if (pc !== 4'd1) begin errors++; $display("FAIL add_pc got %0d want 1", pc); end
      checks++; if (SwpinA !== 2'b01 || ALUdesk !== 2'b00 || datainstr[2:0] !== 3'b101 || datainstr[5:3] !== 3'b100) begin errors++; $display("FAIL add_ctl got swpa=%b alu=%b di=%h want 01 00 src101 dst100", SwpinA, ALUdesk, datainstr); end
      tick();
      checks++; if (pc !== 4'd0) begin errors++; $display("FAIL add_wrap got %0d want 0", pc); end
   endtask

   task automatic test_jumps();
      do_reset();
      for (int i = 0; i < 8; i++) load(4'(i), w(4'd0, 3'b0, 3'b0, 8'd0));
      load(4'd0, w(4'd8, 3'b0, 3'b0, 8'd3));
      load(4'd3, w(4'd11, 3'b0, 3'b0, 8'd6));
      load(4'd6, w(4'd10, 3'b0, 3'b0, 8'd2));
      run = 1'b1;
      ACCond = 8'd0;
      tick();
      checks++; if (jmpInstr !== 1'b1) begin errors++; $display("FAIL jez_jmp got %b want 1", jmpInstr); end
      tick();
      checks++; if (pc !== 4'd3) begin errors++; $display("FAIL jez_pc got %0d want 3", pc); end
      ACCond = 8'hFF;
      #1;
      checks++; if (jmpInstr !== 1'b1) begin errors++; $display("FAIL jlz_jmp got %b want 1", jmpInstr); end
      tick();
      checks++; if (pc !== 4'd6) begin errors++; $display("FAIL jlz_pc got %0d want 6", pc); end
      checks++; if (jmpInstr !== 1'b1) begin errors++; $display("FAIL jgz_jmp got %b want 1", jmpInstr); end
      tick();
      checks++; if (pc !== 4'd7) begin errors++; $display("FAIL jgz_pc got %0d want 7", pc); end
      tick();
      checks++; if (pc !== 4'd0) begin errors++; $display("FAIL len_wrap got %0d want 0", pc); end
   endtask

   task automatic test_stall_in();
      do_reset();
      load(4'd0, w(4'd1, 3'b010, 3'b100, 8'd0));
      load(4'd1, w(4'd0, 3'b0, 3'b0, 8'd0));
      run = 1'b1;
      tick();
      checks++; if (pif.in_ack !== 4'b0 || jmpInstr !== 1'b1) begin errors++; $display("FAIL in_stall got ack=%b jmp=%b want 0000 1", pif.in_ack, jmpInstr); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (state !== 2'b10 || pc !== 4'd0 || jmpInstr !== 1'b1) begin errors++; $display("FAIL in_wait%0d got st=%0d pc=%0d jmp=%b want 2 0 1", i, state, pc, jmpInstr); end
      end
      pif.in_valid = 4'b0100;
      #1;
      checks++; if (pif.in_ack !== 4'b0100 || jmpInstr !== 1'b0) begin errors++; $display("FAIL in_ack got ack=%b jmp=%b want 0100 0", pif.in_ack, jmpInstr); end
      tick();
      checks++; if (pc !== 4'd1 || state !== 2'b01 || pif.in_ack !== 4'b0) begin errors++; $display("FAIL in_resume got pc=%0d st=%0d ack=%b want 1 1 0000", pc, state, pif.in_ack); end
      pif.in_valid = 4'b0;
   endtask

   task automatic test_stall_out();
      do_reset();
      load(4'd0, w(4'd1, 3'b100, 3'b001, 8'd0));
      load(4'd1, w(4'd1, 3'b100, 3'b001, 8'd0));
      load(4'd2, w(4'd0, 3'b0, 3'b0, 8'd0));
      run = 1'b1;
      tick();
      checks++; if (jmpInstr !== 1'b0) begin errors++; $display("FAIL out_first got jmp=%b want 0", jmpInstr); end
      tick();
      checks++; if (pif.out_valid !== 4'b0010 || jmpInstr !== 1'b1) begin errors++; $display("FAIL out_block got ov=%b jmp=%b want 0010 1", pif.out_valid, jmpInstr); end
      tick();
      checks++; if (state !== 2'b10 || pc !== 4'd1) begin errors++; $display("FAIL out_wait got st=%0d pc=%0d want 2 1", state, pc); end
      pif.out_ack = 4'b0010;
      #1;
      checks++; if (jmpInstr !== 1'b0) begin errors++; $display("FAIL out_release got jmp=%b want 0", jmpInstr); end
      tick();
      pif.out_ack = 4'b0;
      checks++; if (pif.out_valid !== 4'b0010 || pc !== 4'd2 || state !== 2'b01) begin errors++; $display("FAIL out_commit got ov=%b pc=%0d st=%0d want 0010 2 1", pif.out_valid, pc, state); end
      tick();
      checks++; if (pif.out_valid !== 4'b0010 || pc !== 4'd0) begin errors++; $display("FAIL out_hold got ov=%b pc=%0d want 0010 0", pif.out_valid, pc); end
      run = 1'b0;
      pif.out_ack = 4'b0010;
      tick();
      pif.out_ack = 4'b0;
      checks++; if (pif.out_valid !== 4'b0 || state !== 2'b00 || pc !== 4'd0) begin errors++; $display("FAIL out_clear got ov=%b st=%0d pc=%0d want 0000 0 0", pif.out_valid, state, pc); end
   endtask

   task automatic test_jro();
      do_reset();
      load(4'd0, w(4'd7, 3'b0, 3'b0, 8'd3));
      load(4'd1, w(4'd0, 3'b0, 3'b0, 8'd0));
      load(4'd2, w(4'd0, 3'b0, 3'b0, 8'd0));
      load(4'd3, w(4'd12, 3'b0, 3'b0, 8'd20));
      load(4'd4, w(4'd0, 3'b0, 3'b0, 8'd0));
      load(4'd5, w(4'd7, 3'b0, 3'b0, 8'd12));
      run = 1'b1;
      tick();
      tick();
      checks++; if (pc !== 4'd3) begin errors++; $display("FAIL jmp3_pc got %0d want 3", pc); end
      tick();
      checks++; if (pc !== 4'd5) begin errors++; $display("FAIL jro_hi got %0d want 5", pc); end
      tick();
      checks++; if (pc !== 4'd0) begin errors++; $display("FAIL jmp_oob got %0d want 0", pc); end
      run = 1'b0;
      tick();
      load(4'd0, w(4'd0, 3'b0, 3'b0, 8'd0));
      load(4'd2, w(4'd12, 3'b0, 3'b0, 8'hFB));
      run = 1'b1;
      tick();
      tick();
      tick();
      checks++; if (pc !== 4'd2) begin errors++; $display("FAIL jro_pre got %0d want 2", pc); end
      tick();
      checks++; if (pc !== 4'd0) begin errors++; $display("FAIL jro_lo got %0d want 0", pc); end
   endtask

   task automatic test_reset_wait();
      do_reset();
      load(4'd0, w(4'd1, 3'b100, 3'b011, 8'd0));
      load(4'd1, w(4'd1, 3'b000, 3'b100, 8'd0));
      run = 1'b1;
      tick();
      tick();
      tick();
      checks++; if (state !== 2'b10 || pif.out_valid !== 4'b1000) begin errors++; $display("FAIL rw_wait got st=%0d ov=%b want 2 1000", state, pif.out_valid); end
      rst_n = 1'b0;
      pif.in_valid = 4'b0001;
      tick();
      rst_n = 1'b1;
      pif.in_valid = 4'b0;
      checks++; if (state !== 2'b00 || pc !== 4'd0 || pif.out_valid !== 4'b0) begin errors++; $display("FAIL rw_reset got st=%0d pc=%0d ov=%b want 0 0 0000", state, pc, pif.out_valid); end
      tick();
      checks++; if (state !== 2'b01 || jmpInstr !== 1'b1 || SwpinA !== 2'b10 || datainstr[5:3] !== 3'b110) begin errors++; $display("FAIL rw_idle got st=%0d jmp=%b swpa=%b dst=%b want 1 1 10 110", state, jmpInstr, SwpinA, datainstr[5:3]); end
      tick();
      checks++; if (pc !== 4'd0) begin errors++; $display("FAIL rw_pc got %0d want 0", pc); end
   endtask

   initial begin
      prog_addr = 4'd0;
      prog_data = 18'd0;
      test_reset();
      test_mov_add();
      test_jumps();
      test_stall_in();
      test_stall_out();
      test_jro();
      test_reset_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
